// File: rtl/addsub_st.sv
`default_nettype none
// ============================================================================
// Module   : addsub_st
// Brief    : 8-bit registered add/sub/inc/dec unit on one ripple-carry adder,
//            with zero, carry and signed-overflow flags.
// Revision : 1.0 - initial release
// ============================================================================

module addsub_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module addsub_st #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S3,
    input  logic             S2,
    output logic             Z,
    output logic             C,
    output logic             O,
    output logic [WIDTH-1:0] S
);
    localparam logic [1:0] c_OP_INC = 2'b00;
    localparam logic [1:0] c_OP_DEC = 2'b01;
    localparam logic [1:0] c_OP_ADD = 2'b10;
    localparam logic [1:0] c_OP_SUB = 2'b11;

    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] s_d, s_q;
    logic             z_d, z_q;
    logic             c_d, c_q;
    logic             o_d, o_q;

    assign w_op = {S3, S2};

    // Every operation is steered onto X + Y + cin with X fixed to A.
    always_comb begin
        w_y   = '0;
        w_cin = 1'b0;
        case (w_op)
            c_OP_ADD: begin w_y = B;       w_cin = 1'b0; end
            c_OP_SUB: begin w_y = ~B;      w_cin = 1'b1; end
            c_OP_INC: begin w_y = '0;      w_cin = 1'b1; end
            c_OP_DEC: begin w_y = '1;      w_cin = 1'b0; end
            default:  begin w_y = '0;      w_cin = 1'b0; end
        endcase
    end

    assign w_carry[0] = w_cin;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        addsub_fa u_fa (
            .a_i  (A[g]),
            .b_i  (w_y[g]),
            .ci_i (w_carry[g]),
            .s_o  (w_sum[g]),
            .co_o (w_carry[g+1])
        );
    end

    always_comb begin
        s_d = w_sum;
        z_d = (w_sum == '0);
        c_d = w_carry[WIDTH];
        // Overflow: carry into the sign bit disagrees with carry out of it.
        o_d = w_carry[WIDTH] ^ w_carry[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
            z_q <= 1'b0;
            c_q <= 1'b0;
            o_q <= 1'b0;
        end else begin
            s_q <= s_d;
            z_q <= z_d;
            c_q <= c_d;
            o_q <= o_d;
        end
    end

    assign S = s_q;
    assign Z = z_q;
    assign C = c_q;
    assign O = o_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_st.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_st
// Brief    : Self-checking bench for addsub_st: directed vectors, reset
//            behaviour and randomized operations against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_addsub_st;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       S3 = 1'b0;
    logic       S2 = 1'b0;
    wire        Z, C, O;
    wire  [7:0] S;

    int n_cmp  = 0;
    int n_fail = 0;

    addsub_st dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .S3    (S3),
        .S2    (S2),
        .Z     (Z),
        .C     (C),
        .O     (O),
        .S     (S)
    );

    always #5 clk = ~clk;

    // Packed as {S, Z, C, O}
    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed S=%h Z=%b C=%b O=%b, expected S=%h Z=%b C=%b O=%b",
                     tag, obs[10:3], obs[2], obs[1], obs[0], exp[10:3], exp[2], exp[1], exp[0]);
            $error("comparison %s did not match", tag);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
        int ua, ub, sa, sb, ru, rs;
        logic c, o, z;
        logic [7:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            2'b10:   begin ru = ua + ub; rs = sa + sb; c = (ru > 255);   end
            2'b11:   begin ru = ua - ub; rs = sa - sb; c = (ua >= ub);   end
            2'b00:   begin ru = ua + 1;  rs = sa + 1;  c = (ua == 255);  end
            default: begin ru = ua - 1;  rs = sa - 1;  c = (ua != 0);    end
        endcase
        res = ru[7:0];
        o   = (rs > 127) || (rs < -128);
        z   = (res == 8'h00);
        return {res, z, c, o};
    endfunction

    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        @(negedge clk);
        A = a;
        B = b;
        {S3, S2} = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [1:0] rop;

        // Reset in force from time zero, before any clock edge
        A = 8'h94; B = 8'hCB; {S3, S2} = 2'b10;
        #1;
        chk("reset_initial", {S, Z, C, O}, 11'h000);
        @(posedge clk); #1;
        chk("reset_held_over_edge", {S, Z, C, O}, 11'h000);

        @(negedge clk);
        rst_n = 1'b1;

        step(8'h94, 8'hCB, 2'b11); chk("sub_94_cb", {S, Z, C, O}, {8'hC9, 3'b000});
        step(8'h94, 8'hCB, 2'b10); chk("add_94_cb", {S, Z, C, O}, {8'h5F, 3'b011});
        step(8'h14, 8'h8B, 2'b11); chk("sub_14_8b", {S, Z, C, O}, {8'h89, 3'b001});
        step(8'h14, 8'h0F, 2'b10); chk("add_14_0f", {S, Z, C, O}, {8'h23, 3'b000});
        step(8'h14, 8'hFB, 2'b01); chk("dec_14",    {S, Z, C, O}, {8'h13, 3'b010});
        step(8'h7F, 8'hFB, 2'b00); chk("inc_7f",    {S, Z, C, O}, {8'h80, 3'b001});
        step(8'h55, 8'h55, 2'b11); chk("sub_equal", {S, Z, C, O}, {8'h00, 3'b110});
        step(8'hFF, 8'h3C, 2'b00); chk("inc_ff",    {S, Z, C, O}, {8'h00, 3'b110});
        step(8'h00, 8'hA5, 2'b01); chk("dec_00",    {S, Z, C, O}, {8'hFF, 3'b000});
        step(8'h80, 8'h00, 2'b01); chk("dec_80",    {S, Z, C, O}, {8'h7F, 3'b011});

        // Outputs must hold while inputs move between edges
        A = 8'h12; B = 8'h34; {S3, S2} = 2'b10;
        #2;
        chk("hold_between_edges", {S, Z, C, O}, {8'h7F, 3'b011});

        // Mid-stream reset after a nonzero result
        step(8'h94, 8'hCB, 2'b11); chk("pre_reset_result", {S, Z, C, O}, {8'hC9, 3'b000});
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_assert", {S, Z, C, O}, 11'h000);
        @(negedge clk);
        A = 8'h14; B = 8'h0F; {S3, S2} = 2'b10;
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_release_no_update", {S, Z, C, O}, 11'h000);
        @(posedge clk); #1;
        chk("first_edge_after_reset", {S, Z, C, O}, {8'h23, 3'b000});

        // Randomized operations, one per cycle
        for (int i = 0; i < 300; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 2'($urandom_range(0, 3));
            step(ra, rb, rop);
            chk($sformatf("rand_%0d_op%0b_%h_%h", i, rop, ra, rb), {S, Z, C, O}, model(ra, rb, rop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
